car_park_ctrl: RTL and testbench

Parametrised car-park occupancy controller: the next generation of the single-counter parking block. It adds entry and exit barrier-gate state machines, pass-through sensor confirmation, gate time-out, capacity/almost-full/empty status and an optional permit-reserved quota. It sits between the lane sensors (arrival loop, pass loop) and the barrier actuators and display.

---
 rtl/car_park_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_car_park_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/car_park_ctrl.sv
// Car-park occupancy controller with entry/exit barrier FSMs, pass confirmation and gate time-out.
// Optional permit-reserved quota is enabled by defining CARPARK_RESERVE_EN.
module car_park_ctrl #(
  parameter int CAPACITY       = 100,
  parameter int COUNT_W        = 8,
  parameter int GATE_TIMEOUT   = 16,
  parameter int ALMOST_FULL_TH = 90,
  parameter int RESERVED       = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               carIn,
  input  logic               carOut,
  input  logic               permit,
  input  logic               entry_pass,
  input  logic               exit_pass,
  output logic               entry_open,
  output logic               exit_open,
  output logic               reject,
  output logic               gate_timeout,
  output logic               Full,
  output logic               AlmostFull,
  output logic               Empty,
  output logic [COUNT_W-1:0] count
);

  localparam int TW = $clog2(GATE_TIMEOUT);
  localparam logic [TW-1:0]      TMAX_C   = TW'(GATE_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] CAP_C    = COUNT_W'(CAPACITY);
  localparam logic [COUNT_W-1:0] AF_C     = COUNT_W'(ALMOST_FULL_TH);
  localparam logic [COUNT_W-1:0] RESLIM_C = COUNT_W'(CAPACITY - RESERVED);

  typedef enum logic {E_IDLE = 1'b0, E_OPEN = 1'b1} e_state_t;
  typedef enum logic {X_IDLE = 1'b0, X_OPEN = 1'b1} x_state_t;

  e_state_t           r_e_state, w_e_nxt;
  x_state_t           r_x_state, w_x_nxt;
  logic [TW-1:0]      r_e_tmr, w_e_tmr_nxt, r_x_tmr, w_x_tmr_nxt;
  logic               r_in_d, r_out_d;
  logic               r_reject, r_gate_to;
  logic               r_full, r_afull, r_empty;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  logic               w_in_rise, w_out_rise, w_admit;
  logic               w_inc, w_dec, w_reject_nxt, w_e_to, w_x_to;

  assign w_in_rise  = carIn & ~r_in_d;
  assign w_out_rise = carOut & ~r_out_d;

`ifdef CARPARK_RESERVE_EN
  assign w_admit = permit ? (r_count < CAP_C) : (r_count < RESLIM_C);
`else
  logic w_unused;
  assign w_unused = ^{permit, RESLIM_C};
  assign w_admit  = (r_count < CAP_C);
`endif

  // Entry gate next-state: request on carIn rise, close on pass or time-out
  always_comb begin
    w_e_nxt      = r_e_state;
    w_e_tmr_nxt  = r_e_tmr;
    w_reject_nxt = 1'b0;
    w_e_to       = 1'b0;
    w_inc        = 1'b0;
    case (r_e_state)
      E_IDLE: begin
        if (w_in_rise && w_admit) begin
          w_e_nxt     = E_OPEN;
          w_e_tmr_nxt = {TW{1'b0}};
        end else if (w_in_rise) begin
          w_reject_nxt = 1'b1;
        end else begin
          w_e_nxt = E_IDLE;
        end
      end
      E_OPEN: begin
        if (entry_pass) begin
          w_inc   = 1'b1;
          w_e_nxt = E_IDLE;
        end else if (r_e_tmr == TMAX_C) begin
          w_e_to  = 1'b1;
          w_e_nxt = E_IDLE;
        end else begin
          w_e_tmr_nxt = r_e_tmr + TW'(1);
        end
      end
      default: w_e_nxt = E_IDLE;
    endcase
  end

  // Exit gate next-state: an empty car park ignores exit requests silently
  always_comb begin
    w_x_nxt     = r_x_state;
    w_x_tmr_nxt = r_x_tmr;
    w_x_to      = 1'b0;
    w_dec       = 1'b0;
    case (r_x_state)
      X_IDLE: begin
        if (w_out_rise && !r_empty) begin
          w_x_nxt     = X_OPEN;
          w_x_tmr_nxt = {TW{1'b0}};
        end else begin
          w_x_nxt = X_IDLE;
        end
      end
      X_OPEN: begin
        if (exit_pass) begin
          w_dec   = 1'b1;
          w_x_nxt = X_IDLE;
        end else if (r_x_tmr == TMAX_C) begin
          w_x_to  = 1'b1;
          w_x_nxt = X_IDLE;
        end else begin
          w_x_tmr_nxt = r_x_tmr + TW'(1);
        end
      end
      default: w_x_nxt = X_IDLE;
    endcase
  end

  // Saturating occupancy update; simultaneous entry and exit cancel
  always_comb begin
    w_count_nxt = r_count;
    if (w_inc && !w_dec) begin
      if (r_count < CAP_C) begin
        w_count_nxt = r_count + COUNT_W'(1);
      end else begin
        w_count_nxt = r_count;
      end
    end else if (w_dec && !w_inc) begin
      if (r_count != {COUNT_W{1'b0}}) begin
        w_count_nxt = r_count - COUNT_W'(1);
      end else begin
        w_count_nxt = r_count;
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // State, timers, pulses and status flags (flags decoded from next count so they track count)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e_state <= E_IDLE;
      r_x_state <= X_IDLE;
      r_e_tmr   <= {TW{1'b0}};
      r_x_tmr   <= {TW{1'b0}};
      r_in_d    <= 1'b0;
      r_out_d   <= 1'b0;
      r_reject  <= 1'b0;
      r_gate_to <= 1'b0;
      r_count   <= {COUNT_W{1'b0}};
      r_full    <= 1'b0;
      r_afull   <= (ALMOST_FULL_TH == 0);
      r_empty   <= 1'b1;
    end else begin
      r_e_state <= w_e_nxt;
      r_x_state <= w_x_nxt;
      r_e_tmr   <= w_e_tmr_nxt;
      r_x_tmr   <= w_x_tmr_nxt;
      r_in_d    <= carIn;
      r_out_d   <= carOut;
      r_reject  <= w_reject_nxt;
      r_gate_to <= w_e_to | w_x_to;
      r_count   <= w_count_nxt;
      r_full    <= (w_count_nxt == CAP_C);
      r_afull   <= (w_count_nxt >= AF_C);
      r_empty   <= (w_count_nxt == {COUNT_W{1'b0}});
    end
  end

  assign entry_open   = (r_e_state == E_OPEN);
  assign exit_open    = (r_x_state == X_OPEN);
  assign reject       = r_reject;
  assign gate_timeout = r_gate_to;
  assign Full         = r_full;
  assign AlmostFull   = r_afull;
  assign Empty        = r_empty;
  assign count        = r_count;

endmodule

// File: tb/tb_car_park_ctrl.sv
// Directed self-checking bench for car_park_ctrl (CAPACITY=4, GATE_TIMEOUT=8, ALMOST_FULL_TH=3, RESERVED=1).
module tb_car_park_ctrl;

`ifdef CARPARK_RESERVE_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic       clk, reset, carIn, carOut, permit, entry_pass, exit_pass;
  logic       entry_open, exit_open, reject, gate_timeout, Full, AlmostFull, Empty;
  logic [2:0] count;
  int         n_cmp, n_err;
  int         open_cnt, to_cnt;

  car_park_ctrl #(
    .CAPACITY(4), .COUNT_W(3), .GATE_TIMEOUT(8), .ALMOST_FULL_TH(3), .RESERVED(1)
  ) dut (
    .clk(clk), .reset(reset), .carIn(carIn), .carOut(carOut), .permit(permit),
    .entry_pass(entry_pass), .exit_pass(exit_pass), .entry_open(entry_open),
    .exit_open(exit_open), .reject(reject), .gate_timeout(gate_timeout),
    .Full(Full), .AlmostFull(AlmostFull), .Empty(Empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int c);
    chk({tag, "_count"}, 32'(count), c);
    chk({tag, "_full"}, 32'(Full), (c == 4) ? 1 : 0);
    chk({tag, "_afull"}, 32'(AlmostFull), (c >= 3) ? 1 : 0);
    chk({tag, "_empty"}, 32'(Empty), (c == 0) ? 1 : 0);
  endtask

  task automatic do_entry(input int exp_c);
    carIn = 1'b1;
    tick();
    chk("entry_open", 32'(entry_open), 1);
    carIn = 1'b0;
    tick();
    tick();
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    chk("entry_closed", 32'(entry_open), 0);
    chk_flags("entry", exp_c);
  endtask

  task automatic do_exit(input int exp_c);
    carOut = 1'b1;
    tick();
    chk("exit_open", 32'(exit_open), 1);
    carOut = 1'b0;
    tick();
    exit_pass = 1'b1;
    tick();
    exit_pass = 1'b0;
    chk("exit_closed", 32'(exit_open), 0);
    chk_flags("exit", exp_c);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; carIn = 1'b0; carOut = 1'b0; permit = 1'b0;
    entry_pass = 1'b0; exit_pass = 1'b0;
    tick();
    tick();
    chk_flags("rst", 0);
    chk("rst_entry_open", 32'(entry_open), 0);
    chk("rst_exit_open", 32'(exit_open), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_timeout", 32'(gate_timeout), 0);
    reset = 1'b0;
    tick();

    // Fill to capacity
    for (int i = 1; i <= 4; i++) do_entry(i);

    // Request when full is rejected for one cycle
    carIn = 1'b1;
    tick();
    chk("full_reject", 32'(reject), 1);
    chk("full_no_open", 32'(entry_open), 0);
    carIn = 1'b0;
    tick();
    chk("full_reject_pulse", 32'(reject), 0);
    chk("full_count", 32'(count), 4);

    for (int i = 3; i >= 0; i--) do_exit(i);

    // Time-out: open exactly 8 cycles, one pulse
    open_cnt = 0; to_cnt = 0;
    carIn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      carIn = 1'b0;
      open_cnt += 32'(entry_open);
      to_cnt   += 32'(gate_timeout);
    end
    chk("to_open_cycles", open_cnt, 8);
    chk("to_pulses", to_cnt, 1);
    chk("to_count", 32'(count), 0);

    // Exit request while empty is ignored
    carOut = 1'b1;
    tick();
    chk("empty_exit_open", 32'(exit_open), 0);
    chk("empty_exit_reject", 32'(reject), 0);
    carOut = 1'b0;
    tick();
    chk("empty_exit_open2", 32'(exit_open), 0);

    // Simultaneous entry and exit commit
    do_entry(1);
    do_entry(2);
    carIn = 1'b1; carOut = 1'b1;
    tick();
    chk("both_entry_open", 32'(entry_open), 1);
    chk("both_exit_open", 32'(exit_open), 1);
    carIn = 1'b0; carOut = 1'b0;
    tick();
    entry_pass = 1'b1; exit_pass = 1'b1;
    tick();
    entry_pass = 1'b0; exit_pass = 1'b0;
    chk("both_count", 32'(count), 2);
    chk("both_entry_closed", 32'(entry_open), 0);
    chk("both_exit_closed", 32'(exit_open), 0);
    exit_pass = 1'b1;
    tick();
    exit_pass = 1'b0;
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    tick();
    chk("stray_count", 32'(count), 2);

    // Reserved quota at count=3
    do_entry(3);
    permit = 1'b0; carIn = 1'b1;
    tick();
    chk("res_a_reject", 32'(reject), RES_EN ? 1 : 0);
    chk("res_a_open", 32'(entry_open), RES_EN ? 0 : 1);
    carIn = 1'b0;
    tick();
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    chk("res_a_count", 32'(count), RES_EN ? 3 : 4);
    permit = 1'b1; carIn = 1'b1;
    tick();
    chk("res_b_reject", 32'(reject), RES_EN ? 0 : 1);
    chk("res_b_open", 32'(entry_open), RES_EN ? 1 : 0);
    carIn = 1'b0;
    tick();
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0; permit = 1'b0;
    chk("res_b_count", 32'(count), 4);

    // Asynchronous reset mid-operation, then release with carIn held
    do_exit(3);
    do_exit(2);
    carIn = 1'b1;
    tick();
    chk("pre_rst_open", 32'(entry_open), 1);
    reset = 1'b1;
    #1;
    chk("arst_entry_open", 32'(entry_open), 0);
    chk_flags("arst", 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rel_entry_open", 32'(entry_open), 1);
    tick();
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    chk("rel_count", 32'(count), 1);
    tick();
    tick();
    chk("held_no_retrigger", 32'(entry_open), 0);
    chk("held_no_reject", 32'(reject), 0);
    carIn = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
